// File: rtl/seq_match_pkg.sv
// Shared types and constants for the programmable serial sequence-match controller.
package seq_match_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int LEN_W     = $clog2(PAT_W_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Plain vector encodings kept for blocks that carry state as logic [1:0].
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ARMED = ST_ARMED;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  function automatic logic len_ok(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_shift.sv
// History shift register, saturating bit counter and length-masked pattern compare.
// Build option SEQ_MATCH_NONOVERLAP_EN: bit count restarts after each hit (non-overlapping).
module seq_match_shift
  import seq_match_pkg::*;
#(
  parameter int PAT_W   = PAT_W_DEF,
  parameter int LEN_W_P = $clog2(PAT_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               din,
  input  logic [PAT_W-1:0]   pattern,
  input  logic [LEN_W_P-1:0] len,
  output logic               hit
);

  logic [PAT_W-1:0]   hist_q;
  logic [PAT_W-1:0]   hist_nxt;
  logic [PAT_W-1:0]   mask;
  logic [LEN_W_P-1:0] cnt_q;
  logic [LEN_W_P-1:0] cnt_nxt;

  // Compare is against the post-shift view so hit lines up with the sampling edge.
  always_comb begin
    hist_nxt = {hist_q[PAT_W-2:0], din};
    cnt_nxt  = cnt_q;
    if (cnt_q != LEN_W_P'(PAT_W))
      cnt_nxt = cnt_q + 1'b1;
    for (int i = 0; i < PAT_W; i++)
      mask[i] = (i < int'(len));
    hit = shift_en && (len != '0) &&
          ((hist_nxt & mask) == (pattern & mask)) &&
          (cnt_nxt >= len);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en) begin
      hist_q <= hist_nxt;
`ifdef SEQ_MATCH_NONOVERLAP_EN
      cnt_q  <= hit ? '0 : cnt_nxt;
`else
      cnt_q  <= cnt_nxt;
`endif
    end
  end

endmodule

// File: rtl/seq_match_ctrl.sv
// Sequenced serial pattern-match controller: config handshake, arm, run, stop after target.
// Build option SEQ_MATCH_NONOVERLAP_EN selects non-overlapping detection in seq_match_shift.
//
// state | meaning
// IDLE  | no valid config; accepts config, ignores start
// ARMED | config held; waits for start
// RUN   | sampling serial stream, counting matches
// DONE  | target reached; start re-runs, config re-arms
module seq_match_ctrl
  import seq_match_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic [CNT_W-1:0]           cfg_target,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic                       in,
  output logic                       match,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int LW = $clog2(PAT_W + 1);

  logic [1:0]       state_q;
  logic [PAT_W-1:0] pattern_q;
  logic [LW-1:0]    len_q;
  logic [CNT_W-1:0] target_q;
  logic             match_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic             cfg_err_q;

  logic             cfg_fire;
  logic             len_legal;
  logic             run_go;
  logic             shift_en;
  logic             hit;
  logic [CNT_W-1:0] cnt_inc;

  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign len_legal = len_ok(int'(cfg_len), PAT_W);
  // A config handshake in DONE takes priority over a simultaneous start.
  assign run_go    = start && ((state_q == S_ARMED) ||
                               ((state_q == S_DONE) && !cfg_fire));
  assign shift_en  = (state_q == S_RUN) && in_valid;
  assign cnt_inc   = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + 1'b1;

  seq_match_shift #(
    .PAT_W   (PAT_W),
    .LEN_W_P (LW)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (run_go),
    .shift_en (shift_en),
    .din      (in),
    .pattern  (pattern_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      target_q    <= '0;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      match_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (cfg_fire) begin
            if (len_legal) begin
              pattern_q <= cfg_pattern;
              len_q     <= cfg_len;
              target_q  <= cfg_target;
              cfg_err_q <= 1'b0;
              state_q   <= S_ARMED;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end else if (run_go) begin
            match_cnt_q <= '0;
            state_q     <= S_RUN;
          end
        end
        S_ARMED: begin
          if (run_go) begin
            match_cnt_q <= '0;
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          if (hit) begin
            match_q     <= 1'b1;
            match_cnt_q <= cnt_inc;
            if ((target_q != '0) && (cnt_inc == target_q))
              state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign match     = match_q;
  assign match_cnt = match_cnt_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign cfg_err   = cfg_err_q;

endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
Programmable controller for the serial sequence-detector datapath. It loads a pattern and length through a config handshake and arms on START. It then samples the qualified serial bit stream, pulses MATCH on each detection and counts detections. It stops with DONE after a programmed number of matches. It sits between the host/config logic and the raw serial input, replacing a fixed-pattern fsm with a sequenced, reusable one.

Parameters:
PAT_W, 8, maximum pattern length in bits (history register width)
CNT_W, 8, width of match target and match counter

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
CFG_VALID  input  1  config request
CFG_READY  output  1  config accepted when CFG_VALID&&CFG_READY; high only in IDLE and DONE
CFG_PATTERN  input  PAT_W  pattern; first-received bit is CFG_PATTERN[LEN-1], last is [0]
CFG_LEN  input  $clog2(PAT_W+1)  pattern length, legal 1..PAT_W
CFG_TARGET  input  CNT_W  matches before DONE; 0 = run forever
START  input  1  arm/run request
IN_VALID  input  1  IN is sampled only when high
IN  input  1  serial data bit
MATCH  output  1  one-cycle pulse per detection
MATCH_CNT  output  CNT_W  detections since START, saturating
BUSY  output  1  high in RUN
DONE  output  1  high in DONE state
CFG_ERR  output  1  sticky: illegal CFG_LEN rejected

Behaviour:
- Reset (async, RST=1): state=IDLE; pattern=0, len=0, target=0, history=0, bit count=0; MATCH=0, MATCH_CNT=0, BUSY=0, DONE=0, CFG_ERR=0. CFG_READY=1 after reset.
- States: IDLE, ARMED, RUN, DONE.
- IDLE: a config handshake with legal CFG_LEN latches pattern/len/target -> ARMED and clears CFG_ERR. Illegal CFG_LEN (0 or >PAT_W) sets CFG_ERR and stays in IDLE. START is ignored in IDLE.
- ARMED: CFG_READY=0. START -> RUN next cycle; history, bit count and MATCH_CNT cleared on that edge.
- RUN: on each IN_VALID cycle, history <= {history[PAT_W-2:0], IN} and bit count increments, saturating at PAT_W.
  - Detection when the updated history[len-1:0] == pattern[len-1:0] and the updated bit count >= len.
  - MATCH is registered: high exactly the cycle after the completing IN_VALID sample.
  - MATCH_CNT increments on the same edge that MATCH rises; it saturates at 2^CNT_W-1.
  - Overlapping detection by default: history is not cleared after a match.
  - When target!=0 and the increment makes MATCH_CNT==target, the next state is DONE on the same edge; MATCH still pulses.
  - IN_VALID=0 cycles do not shift, count or match. START in RUN is ignored.
- DONE: DONE=1, BUSY=0, MATCH_CNT held, CFG_READY=1. START re-runs with the stored config (-> RUN, counter cleared). A legal config handshake -> ARMED; a config handshake wins over a simultaneous START.
- Reset asserted mid-RUN aborts immediately to IDLE with all outputs at reset values; the stored config is lost.
- RUN has no exit other than target reached or reset.

Optional Feature:
SEQ_MATCH_NONOVERLAP_EN
- Defined: on a detection, the bit count is cleared to 0 on that edge, so the next match needs len fresh bits (non-overlapping). History still shifts.
- Undefined: overlapping detection as above.

Decomposition:
- Package seq_match_pkg:
  - state enum (IDLE, ARMED, RUN, DONE)
  - PAT_W/CNT_W defaults
  - localparam LEN_W = $clog2(PAT_W+1)
- One sub-module, seq_match_shift: the history shift register plus bit counter plus length-masked compare, producing a combinational hit for the controller FSM.

Test Plan:
1. Reset: RST=1 for 3 cycles mid-stream -> all outputs 0, CFG_READY=1, state IDLE.
2. Config pattern=8'h33, len=8, target=1; START; stream 0,0,1,1,0,0,1,1 with IN_VALID=1 -> MATCH pulses one cycle after the 8th bit, MATCH_CNT=1, DONE=1 next to that, BUSY=0.
3. Overlap: pattern=3'b101 (len=3), target=0; stream 1,0,1,0,1 -> two MATCH pulses (after bits 3 and 5), MATCH_CNT=2. With SEQ_MATCH_NONOVERLAP_EN -> one pulse, MATCH_CNT=1.
4. Gaps: repeat test 2 with IN_VALID low for 2 cycles between every bit -> same single MATCH, timed one cycle after the last valid bit.
5. Illegal config: CFG_LEN=0, then CFG_LEN=9 with PAT_W=8 -> CFG_ERR=1, stays IDLE, START ignored. A legal config then clears CFG_ERR.
6. DONE re-run: after test 2, START again with the same stream -> MATCH_CNT restarts at 0 and reaches 1, DONE reasserts. Simultaneous CFG_VALID and START in DONE -> ARMED, not RUN.
